// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: double-buffered time-multiplexed scan driver for a common-anode 7-segment display
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       value_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic [NUM_DIGITS-1:0]         blank_i,
  input  logic                          lzb_en_i,
  input  logic                          load_i,
  output logic [3:0]                    hex_o,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic                          dp_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_o
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    tc;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;
  logic                    pend_vld;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    off;
  logic                    on;
  assign tc       = cnt == CW'(REFRESH_DIV - 1);
  assign boundary = tc && idx == IW'(NUM_DIGITS - 1);
  // slot divider and digit index; idx wraps to 0 at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc) idx <= boundary ? '0 : idx + 1'b1;
    end
  end
  // pending/active double buffer; active only changes at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_vld   <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (load_i) begin
        pend_val   <= value_i;
        pend_dp    <= dp_i;
        pend_blank <= blank_i;
      end
      if (boundary) begin
        pend_vld <= 1'b0;
        if (load_i) begin
          act_val   <= value_i;
          act_dp    <= dp_i;
          act_blank <= blank_i;
        end else if (pend_vld) begin
          act_val   <= pend_val;
          act_dp    <= pend_dp;
          act_blank <= pend_blank;
        end
      end else if (load_i) begin
        pend_vld <= 1'b1;
      end
    end
  end
  // digit k is a leading zero when it and every digit above it are zero; digit 0 never is
  always_comb begin
    lz = '0;
    for (int k = 1; k < NUM_DIGITS; k++) lz[k] = (act_val >> (4 * k)) == '0;
    off = act_blank[idx] | (lzb_en_i & lz[idx]);
    on  = (cnt >= CW'(DEAD_CYCLES)) & ~off;
  end
  // registered output stage, one cycle behind cnt/idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_o       <= '0;
      an_o        <= '1;
      dp_o        <= 1'b1;
      digit_idx_o <= '0;
      frame_o     <= 1'b0;
    end else begin
      hex_o       <= act_val[4*idx +: 4];
      an_o        <= on ? ~(NUM_DIGITS'(1) << idx) : '1;
      dp_o        <= ~(on & act_dp[idx]);
      digit_idx_o <= idx;
      frame_o     <= boundary;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: table vectors, hand sequences and random stimulus against a frame-level model
module tb_seven_seg_scanner;
  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;
  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzb;
    logic [3:0]  lit;
    logic [3:0]  dpl;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic        lzb_en_i = 1'b0;
  logic        load_i = 1'b0;
  logic [3:0]  hex_o;
  logic [3:0]  an_o;
  logic        dp_o;
  logic [1:0]  digit_idx_o;
  logic        frame_o;
  int          checks = 0;
  int          errors = 0;
  int          m_c;
  logic [15:0] a_val, p_val;
  logic [3:0]  a_dp, a_bl, p_dp, p_bl;
  logic        pv;
  vec_t        tbl[7];
  seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
    .lzb_en_i(lzb_en_i), .load_i(load_i), .hex_o(hex_o), .an_o(an_o), .dp_o(dp_o),
    .digit_idx_o(digit_idx_o), .frame_o(frame_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset();
    chk("rst_an", 16'(an_o), 16'hF);
    chk("rst_dp", 16'(dp_o), 16'h1);
    chk("rst_hex", 16'(hex_o), 16'h0);
    chk("rst_frame", 16'(frame_o), 16'h0);
    chk("rst_idx", 16'(digit_idx_o), 16'h0);
  endtask
  task automatic model_reset();
    m_c = 0;
    a_val = '0; a_dp = '0; a_bl = '0;
    p_val = '0; p_dp = '0; p_bl = '0;
    pv = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) begin
      int cnt, idx, msd;
      logic on, e_dp, e_fr;
      logic [3:0] e_hex, e_an;
      cnt = m_c % R;
      idx = (m_c / R) % N;
      msd = 0;
      for (int k = 0; k < N; k++) if (((a_val >> (4 * k)) & 16'hF) != 0) msd = k;
      on    = cnt >= D && !a_bl[idx] && !(lzb_en_i && idx > msd);
      e_hex = 4'((a_val >> (4 * idx)) & 16'hF);
      e_an  = on ? 4'hF & ~4'(1 << idx) : 4'hF;
      e_dp  = !(on && a_dp[idx]);
      e_fr  = (m_c + 1) % (N * R) == 0;
      @(posedge clk);
      if (e_fr) begin
        if (load_i) begin a_val = value_i; a_dp = dp_i; a_bl = blank_i; end
        else if (pv) begin a_val = p_val; a_dp = p_dp; a_bl = p_bl; end
        pv = 1'b0;
      end else if (load_i) pv = 1'b1;
      if (load_i) begin p_val = value_i; p_dp = dp_i; p_bl = blank_i; end
      m_c++;
      #1;
      chk("hex", 16'(hex_o), 16'(e_hex));
      chk("an", 16'(an_o), 16'(e_an));
      chk("dp", 16'(dp_o), 16'(e_dp));
      chk("idx", 16'(digit_idx_o), 16'(idx));
      chk("frame", 16'(frame_o), 16'(e_fr));
    end
  endtask
  task automatic wait_frame();
    int k;
    for (k = 0; k < 100; k++) begin
      step(1);
      if (frame_o === 1'b1) break;
    end
    chk("frame_timeout", 16'(k < 100), 16'h1);
  endtask
  initial begin
    int first;
    logic [15:0] v;
    tbl[0] = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, 4'b1111, 4'b0100};
    tbl[1] = '{16'h0040, 4'b0000, 4'b0000, 1'b1, 4'b0011, 4'b0000};
    tbl[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000};
    tbl[3] = '{16'h0040, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    tbl[4] = '{16'h5678, 4'b1111, 4'b1010, 1'b0, 4'b0101, 4'b0101};
    tbl[5] = '{16'h0300, 4'b0001, 4'b0001, 1'b1, 4'b0110, 4'b0000};
    tbl[6] = '{16'h1000, 4'b1000, 4'b0000, 1'b1, 4'b1111, 4'b1000};
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk_reset();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      value_i = tbl[i].val; dp_i = tbl[i].dp; blank_i = tbl[i].blank; lzb_en_i = tbl[i].lzb;
      load_i = 1'b1;
      step(1);
      load_i = 1'b0;
      value_i = 16'($urandom); dp_i = 4'($urandom); blank_i = 4'($urandom);
      wait_frame();
      step(5);
      v = tbl[i].val;
      for (int s = 0; s < N; s++) begin
        chk("tbl_hex", 16'(hex_o), (v >> (4 * s)) & 16'hF);
        chk("tbl_an", 16'(an_o), tbl[i].lit[s] ? 16'(4'hF & ~4'(1 << s)) : 16'hF);
        chk("tbl_dp", 16'(dp_o), 16'(!tbl[i].dpl[s]));
        if (s < N - 1) step(8);
      end
    end
    lzb_en_i = 1'b0; blank_i = '0; dp_i = '0;
    for (int k = 0; k < 40 && m_c % (N * R) != N * R - 1; k++) step(1);
    value_i = 16'hBEEF; load_i = 1'b1;
    step(1);
    load_i = 1'b0;
    step(5);
    chk("bnd_hex", 16'(hex_o), 16'hF);
    chk("bnd_an", 16'(an_o), 16'hE);
    step(8);
    chk("mid_an", 16'(an_o), 16'hD);
    value_i = 16'h1111; load_i = 1'b1;
    step(1);
    load_i = 1'b0;
    step(7);
    chk("mid_old_hex", 16'(hex_o), 16'hE);
    chk("mid_old_an", 16'(an_o), 16'hB);
    wait_frame();
    step(5);
    chk("mid_new_hex", 16'(hex_o), 16'h1);
    chk("mid_new_an", 16'(an_o), 16'hE);
    step(8);
    chk("rst_pre_an", 16'(an_o), 16'hD);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (frame_o === 1'b1 && first == 0) first = k;
    end
    chk("first_frame", 16'(first), 16'd32);
    for (int i = 0; i < 800; i++) begin
      logic [15:0] mask;
      case ($urandom % 4)
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      value_i = 16'($urandom) & mask;
      dp_i = 4'($urandom);
      blank_i = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      load_i = $urandom % 12 == 0;
      if ($urandom % 40 == 0) lzb_en_i = ~lzb_en_i;
      step(1);
    end
    load_i = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
